// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the 16-bit to 8-bit data-memory controller.
// Holds the state encoding, the data/byte widths and the byte-order helpers.
// Little-endian: the low byte lives at addr and the high byte at addr+1.
package data_mem_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LO_ISSUE = 3'd1,
    LO_WAIT  = 3'd2,
    HI_ISSUE = 3'd3,
    HI_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  // Byte idx of a 16-bit word under the little-endian convention.
  function automatic logic [BYTE_W-1:0] le_byte(input logic [DATA_W-1:0] d,
                                                input logic              idx);
    return idx ? d[15:8] : d[7:0];
  endfunction

  // Rebuild a 16-bit word from its high and low bytes.
  function automatic logic [DATA_W-1:0] le_join(input logic [BYTE_W-1:0] hi,
                                                input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_wait_timer.sv
// Counts the SRAM read wait after each byte issue.
// Loaded on an issue cycle; o_done is high on the last wait cycle.
// No backpressure: it counts whenever the controller is in a wait state.
module mem_wait_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES);

  logic [3:0] r_cnt;

  // Reload on issue, count down while waiting, park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/data_mem_ctrl.sv
// Splits each 16-bit load/store into two byte accesses on an 8-bit SRAM.
// Latency: write response 3 cycles after accept, read 3 + 2*WAIT_CYCLES.
// Ready only in IDLE/RESP; a request held during RESP is taken back-to-back.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BYTE_W-1:0] o_mem_wdata,
  input  logic [BYTE_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_ctrl: WAIT_CYCLES must be within 1..15");
  end

  state_t              r_state, w_next;
  logic                r_req_ready, r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [BYTE_W-1:0]   r_mem_wdata;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTE_W-1:0]   r_rdata_lo;

  logic                w_accept, w_done;
  logic                w_write_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [DATA_W-1:0]   w_wdata_sel;
  logic                w_mem_en, w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [BYTE_W-1:0]   w_mem_wdata;

  // Ready is only ever high in IDLE or RESP, so this is the whole accept rule.
  assign w_accept = i_req_valid & r_req_ready;

  // The low-byte issue directly follows acceptance, before the latches update.
  assign w_write_sel = w_accept ? i_req_write : r_write;
  assign w_addr_sel  = w_accept ? i_req_addr  : r_addr;
  assign w_wdata_sel = w_accept ? i_req_wdata : r_wdata;

  mem_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load ((r_state == LO_ISSUE) || (r_state == HI_ISSUE)),
    .i_dec  ((r_state == LO_WAIT)  || (r_state == HI_WAIT)),
    .o_done (w_done)
  );

  // Next state, plus the SRAM drive for the state being entered.
  always_comb begin
    w_next      = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    unique case (r_state)
      IDLE:     if (w_accept) w_next = LO_ISSUE;
      LO_ISSUE: w_next = r_write ? HI_ISSUE : LO_WAIT;
      LO_WAIT:  if (w_done) w_next = HI_ISSUE;
      HI_ISSUE: w_next = r_write ? RESP : HI_WAIT;
      HI_WAIT:  if (w_done) w_next = RESP;
      RESP:     w_next = w_accept ? LO_ISSUE : IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_next == LO_ISSUE) begin
      w_mem_en    = 1'b1;
      w_mem_we    = w_write_sel;
      w_mem_addr  = w_addr_sel;
      w_mem_wdata = le_byte(w_wdata_sel, 1'b0);
    end else if (w_next == HI_ISSUE) begin
      w_mem_en    = 1'b1;
      w_mem_we    = r_write;
      w_mem_addr  = r_addr + ADDR_W'(1);
      w_mem_wdata = le_byte(r_wdata, 1'b1);
    end
  end

  // State, registered outputs, request latches and read-byte capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_lo  <= '0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == IDLE) || (w_next == RESP);
      r_rsp_valid <= (w_next == RESP);
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      if ((r_state == LO_WAIT) && w_done) r_rdata_lo <= i_mem_rdata;
      if ((r_state == HI_WAIT) && w_done) r_rsp_rdata <= le_join(i_mem_rdata, r_rdata_lo);
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance A uses WAIT_CYCLES=1, instance B uses 3.
// Each instance has its own byte-wide SRAM model; a word-level reference
// memory predicts read data, latency and byte-access addresses.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;

  logic        ready_a, rsp_valid_a, mem_en_a, mem_we_a, busy_a;
  logic [15:0] rsp_rdata_a, mem_addr_a;
  logic [7:0]  mem_wdata_a, mem_rdata_a;
  logic        ready_b, rsp_valid_b, mem_en_b, mem_we_b, busy_b;
  logic [15:0] rsp_rdata_b, mem_addr_b;
  logic [7:0]  mem_wdata_b, mem_rdata_b;

  bit          sel = 1'b0;
  logic        o_ready, o_rsp_valid, o_mem_en, o_mem_we, o_busy;
  logic [15:0] o_rsp_rdata, o_mem_addr;
  logic [7:0]  o_mem_wdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.WAIT_CYCLES(1), .ADDR_W(16)) dut_a (
    .clk(clk), .rst(rst), .i_req_valid(req_valid_a), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(ready_a),
    .o_rsp_valid(rsp_valid_a), .o_rsp_rdata(rsp_rdata_a), .o_mem_en(mem_en_a),
    .o_mem_we(mem_we_a), .o_mem_addr(mem_addr_a), .o_mem_wdata(mem_wdata_a),
    .i_mem_rdata(mem_rdata_a), .o_busy(busy_a));

  data_mem_ctrl #(.WAIT_CYCLES(3), .ADDR_W(16)) dut_b (
    .clk(clk), .rst(rst), .i_req_valid(req_valid_b), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(ready_b),
    .o_rsp_valid(rsp_valid_b), .o_rsp_rdata(rsp_rdata_b), .o_mem_en(mem_en_b),
    .o_mem_we(mem_we_b), .o_mem_addr(mem_addr_b), .o_mem_wdata(mem_wdata_b),
    .i_mem_rdata(mem_rdata_b), .o_busy(busy_b));

  assign o_ready     = sel ? ready_b     : ready_a;
  assign o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign o_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  assign o_mem_en    = sel ? mem_en_b    : mem_en_a;
  assign o_mem_we    = sel ? mem_we_b    : mem_we_a;
  assign o_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
  assign o_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
  assign o_busy      = sel ? busy_b      : busy_a;

  // Power-on SRAM contents: the directed-test bytes, otherwise a hash.
  function automatic logic [7:0] dflt(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h34;
      16'h0011: return 8'h12;
      16'hFFFF: return 8'hAA;
      16'h0000: return 8'h55;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // SRAM models (written only by DUT accesses).
  logic [7:0] sram    [2][65536];
  bit         sram_wr [2][65536];
  logic [7:0] pipe_a [3];
  logic [7:0] pipe_b [3];

  function automatic logic [7:0] sram_rd(input int s, input logic [15:0] a);
    return sram_wr[s][a] ? sram[s][a] : dflt(a);
  endfunction

  // Byte-wide synchronous SRAMs; read data emerges WAIT_CYCLES after enable.
  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) begin
      sram[0][mem_addr_a]    <= mem_wdata_a;
      sram_wr[0][mem_addr_a] <= 1'b1;
    end
    if (mem_en_b && mem_we_b) begin
      sram[1][mem_addr_b]    <= mem_wdata_b;
      sram_wr[1][mem_addr_b] <= 1'b1;
    end
    pipe_a[0] <= (mem_en_a && !mem_we_a) ? sram_rd(0, mem_addr_a) : 8'hEE;
    pipe_b[0] <= (mem_en_b && !mem_we_b) ? sram_rd(1, mem_addr_b) : 8'hEE;
    for (int i = 1; i < 3; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign mem_rdata_a = pipe_a[0];
  assign mem_rdata_b = pipe_b[2];

  // Reference model: expected memory image and last returned read word.
  logic [7:0]  ref_m [2][65536];
  bit          ref_w [2][65536];
  logic [15:0] last_rd [2];

  function automatic logic [7:0] ref_rd(input int s, input logic [15:0] a);
    return ref_w[s][a] ? ref_m[s][a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    req_valid_a = sel ? 1'b0 : v;
    req_valid_b = sel ? v : 1'b0;
  endtask

  // One complete request, checked for latency, byte accesses and result.
  task automatic run_req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input string tag);
    int          n, na, lat, s;
    logic [15:0] a1;
    logic [15:0] ad [2];
    logic        we_seen [2];
    s   = sel ? 1 : 0;
    a1  = a + 16'd1;
    lat = wr ? 3 : 3 + 2 * (sel ? 3 : 1);
    req_write = wr; req_addr = a; req_wdata = d;
    set_valid(1'b1);
    n = 0;
    while (!o_ready && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, o_ready, 1);
    @(negedge clk);
    set_valid(1'b0);
    n = 1; na = 0;
    ad[0] = 16'hxxxx; ad[1] = 16'hxxxx; we_seen[0] = 1'bx; we_seen[1] = 1'bx;
    while (!o_rsp_valid && n < 80) begin
      if (o_mem_en) begin
        if (na < 2) begin ad[na] = o_mem_addr; we_seen[na] = o_mem_we; end
        na++;
      end
      @(negedge clk); n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_n_access"}, na, 2);
    chk({tag, "_addr_lo"}, ad[0], a);
    chk({tag, "_addr_hi"}, ad[1], a1);
    chk({tag, "_we"}, {we_seen[0], we_seen[1]}, {wr, wr});
    if (wr) begin
      ref_m[s][a] = d[7:0];  ref_w[s][a] = 1'b1;
      ref_m[s][a1] = d[15:8]; ref_w[s][a1] = 1'b1;
      chk({tag, "_sram_lo"}, sram[s][a], d[7:0]);
      chk({tag, "_sram_hi"}, sram[s][a1], d[15:8]);
    end else begin
      last_rd[s] = {ref_rd(s, a1), ref_rd(s, a)};
    end
    chk({tag, "_rdata"}, o_rsp_rdata, last_rd[s]);
    @(negedge clk);
    chk({tag, "_strobe_1cyc"}, o_rsp_valid, 0);
    chk({tag, "_idle_ready"}, {o_ready, o_busy}, 2'b10);
  endtask

  initial begin
    int n, bub, rsp_seen;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", {ready_a, rsp_valid_a, rsp_rdata_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a}, 0);
    chk("rst_outs_b", {ready_b, rsp_valid_b, rsp_rdata_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b}, 0);
    rst = 1'b0;
    #1 chk("rst_release_ready", ready_a, 0);
    @(negedge clk);
    chk("first_edge_ready", {ready_a, ready_b, busy_a, busy_b}, 4'b1100);

    // Directed cases on the WAIT_CYCLES=1 instance.
    sel = 1'b0;
    run_req(1'b0, 16'h0010, 16'h0000, "rd_0010");
    chk("rd_0010_value", last_rd[0], 16'h1234);
    run_req(1'b1, 16'h00FF, 16'hBEEF, "wr_00ff");
    run_req(1'b0, 16'hFFFF, 16'h0000, "rd_wrap");
    chk("rd_wrap_value", last_rd[0], 16'h55AA);

    // Back-to-back write then read of the same word.
    req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hCAFE;
    set_valid(1'b1);
    chk("b2b_ready_idle", o_ready, 1);
    @(negedge clk);
    req_write = 1'b0; req_wdata = 16'h0000;
    n = 1;
    while (!o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("b2b_wr_latency", n, 3);
    chk("b2b_ready_in_resp", o_ready, 1);
    ref_m[0][16'h0020] = 8'hFE; ref_w[0][16'h0020] = 1'b1;
    ref_m[0][16'h0021] = 8'hCA; ref_w[0][16'h0021] = 1'b1;
    @(negedge clk);
    set_valid(1'b0);
    n = 1; bub = 0;
    while (!o_rsp_valid && n < 40) begin
      if (!o_busy) bub++;
      @(negedge clk); n++;
    end
    chk("b2b_rd_latency", n, 5);
    chk("b2b_no_bubble", bub, 0);
    chk("b2b_rd_value", o_rsp_rdata, 16'hCAFE);
    last_rd[0] = 16'hCAFE;
    @(negedge clk);

    // WAIT_CYCLES=3 instance, including reset during LO_WAIT.
    sel = 1'b1;
    run_req(1'b0, 16'h0040, 16'h0000, "w3_rd_0040");
    req_write = 1'b0; req_addr = 16'h0040;
    set_valid(1'b1);
    chk("w3_rst_ready", o_ready, 1);
    @(negedge clk);
    set_valid(1'b0);
    chk("w3_rst_lo_issue_en", o_mem_en, 1);
    @(negedge clk);
    chk("w3_rst_in_wait", {o_busy, o_mem_en}, 2'b10);
    rst = 1'b1;
    #1 chk("w3_rst_async", {o_busy, o_mem_en, o_ready}, 3'b000);
    rsp_seen = 0;
    repeat (2) begin @(negedge clk); if (o_rsp_valid) rsp_seen++; end
    rst = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    repeat (12) begin @(negedge clk); if (o_rsp_valid) rsp_seen++; end
    chk("w3_rst_no_rsp", rsp_seen, 0);
    chk("w3_rst_idle", {o_ready, o_busy, o_rsp_rdata}, {2'b10, 16'h0});
    run_req(1'b0, 16'h0040, 16'h0000, "w3_after_rst");

    // Randomized mix of loads and stores on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int k = 0; k < 12; k++) begin
        bit          wr;
        logic [15:0] a, d;
        wr = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0200 + 16'($urandom_range(0, 15));
        d  = 16'($urandom);
        run_req(wr, a, d, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Multi-cycle data-memory controller between the 16-bit core's load/store path and an 8-bit-wide synchronous data SRAM.
- Accepts one 16-bit read or write per request.
- Splits each request into two little-endian byte accesses: the low byte at addr, the high byte at addr+1.
- Returns read data or write completion on a one-cycle response strobe.

Parameters:
- WAIT_CYCLES, 1: cycles from SRAM enable to valid mem_rdata. Legal range 1..15.
- ADDR_W, 16: byte address width. Address arithmetic wraps modulo 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address. Odd values are legal.
- req_wdata  in  16  store data.
- req_ready  out  1  controller can accept a request this cycle.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  16  load result. Valid while rsp_valid is high for a read; holds its value otherwise.
- mem_en  out  1  SRAM byte access enable.
- mem_we  out  1  SRAM write enable. Qualified by mem_en.
- mem_addr  out  ADDR_W  SRAM byte address.
- mem_wdata  out  8  SRAM write byte.
- mem_rdata  in  8  SRAM read byte. Valid in the cycle WAIT_CYCLES after the cycle in which mem_en was high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, wait counter = 0.
  - From the first clk edge after release, IDLE drives req_ready = 1.
- Handshake: a request is accepted on a rising edge where req_valid & req_ready.
  - On acceptance the controller latches addr, wdata and the write flag.
  - req_ready is high only in IDLE and RESP.
  - Request inputs are ignored in all other states.
- States and transitions:
  - IDLE: on accept go to LO_ISSUE; otherwise stay.
  - LO_ISSUE (1 cycle): mem_en = 1, mem_addr = addr, mem_we = write, mem_wdata = wdata[7:0]. Read goes to LO_WAIT; write goes to HI_ISSUE.
  - LO_WAIT (WAIT_CYCLES cycles): mem_en = 0. On the final cycle, capture mem_rdata into rdata[7:0], then go to HI_ISSUE.
  - HI_ISSUE (1 cycle): mem_en = 1, mem_addr = addr + 1 (mod 2**ADDR_W), mem_we = write, mem_wdata = wdata[15:8]. Read goes to HI_WAIT; write goes to RESP.
  - HI_WAIT (WAIT_CYCLES cycles): capture rdata[15:8] on the final cycle, then go to RESP.
  - RESP (1 cycle): rsp_valid = 1. For a read, rsp_rdata = {hi, lo}. On accept go to LO_ISSUE (back-to-back); otherwise go to IDLE.
- Latency, counted in cycles after the accepting edge:
  - Read: rsp_valid in cycle 3 + 2·WAIT_CYCLES.
  - Write: rsp_valid in cycle 3.
  - Sustained throughput is one request per (latency) cycles; no idle bubble between back-to-back requests.
- Outputs: mem_* are registered outputs; mem_we = 0 and mem_wdata = 0 whenever mem_en = 0.
- Wrap-around: addr 0xFFFF produces a high-byte access at 0x0000.
- Ordering: a read issued directly after a write to the same address observes the written data, because the write's HI_ISSUE precedes the read's LO_ISSUE.
- Reset mid-operation:
  - Abandons the transaction immediately; mem_en drops asynchronously.
  - No rsp_valid is produced.
  - A store interrupted after LO_ISSUE leaves only the low byte written. This is accepted behaviour.
- WAIT_CYCLES outside 1..15 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package, for reuse by the core and its bench:
  - state encoding constants IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, RESP (3-bit);
  - DATA_W = 16, BYTE_W = 8;
  - the little-endian byte-order convention.
- One sub-module is natural: mem_wait_timer.
  - Loadable down-counter, 4-bit.
  - Loaded with WAIT_CYCLES on each issue cycle.
  - Asserts done on its final count.
  - Asynchronously reset by rst.
- All remaining logic (FSM, latches, byte assembly) is inline.

Test Plan:
1. Reset check: assert rst for 3 cycles, release → req_ready 0 during reset and 1 on the first edge after release; all other outputs 0; busy 0.
2. Read, WAIT_CYCLES = 1: SRAM[0x0010] = 0x34, SRAM[0x0011] = 0x12; read 0x0010 → mem_addr sequence 0x0010 then 0x0011, mem_we 0; rsp_valid in cycle 5 with rsp_rdata 0x1234.
3. Write: addr 0x00FF, data 0xBEEF → SRAM[0x00FF] = 0xEF, SRAM[0x0100] = 0xBE; rsp_valid in cycle 3; rsp_rdata unchanged.
4. Wrap: SRAM[0xFFFF] = 0xAA, SRAM[0x0000] = 0x55; read 0xFFFF → second mem_addr 0x0000; rsp_rdata 0x55AA.
5. Back-to-back: write 0xCAFE to 0x0020, with a read of 0x0020 held on req_valid → read accepted in the RESP cycle; returns 0xCAFE; no IDLE cycle between the two requests.
6. WAIT_CYCLES = 3 with mid-operation reset:
   - read of 0x0040 → rsp_valid in cycle 9;
   - repeat with rst asserted during LO_WAIT → mem_en 0 immediately and no rsp_valid;
   - a fresh read after release completes normally.
